// File: rtl/wb_arb_pkg.sv
// Shared definitions for the round-robin Wishbone arbiter: FSM state encoding
// and the watchdog counter width helper.
package wb_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_RECOVER = 2'd2
   } arb_state_t;

   // Counter must hold values up to TMO; a disabled watchdog still needs one bit.
   function automatic int cnt_width(input int tmo);
      return (tmo < 1) ? 1 : $clog2(tmo + 1);
   endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first eligible requester after the last
// grant, wrapping modulo N, skipping anything in the exclude mask.
module wb_rr_pick #(
   parameter int N = 3
) (
   input  logic [N-1:0] req_i,
   input  logic [N-1:0] last_i,
   input  logic [N-1:0] excl_i,
   output logic [N-1:0] gnt_o
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic found;

   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      for (int l = 0; l < N; l++) begin
         if (last_i[l]) begin
            for (int k = 1; k <= N; k++) begin
               if (!found && req_i[IW'((l + k) % N)] && !excl_i[IW'((l + k) % N)]) begin
                  gnt_o[IW'((l + k) % N)] = 1'b1;
                  found = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin arbiter sharing one registered Wishbone master among N requesters,
// with a watchdog that aborts a hung transfer and answers it with an error strobe.
module wb_arbiter_rr
   import wb_arb_pkg::*;
#(
   parameter int N   = 3,
   parameter int DW  = 32,
   parameter int AW  = 16,
   parameter int MW  = DW / 8,
   parameter int TMO = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N*AW-1:0] s_addr,
   input  logic [N*DW-1:0] s_wdata,
   input  logic [N*MW-1:0] s_wmsk,
   input  logic [N-1:0]    s_we,
   input  logic [N-1:0]    s_cyc,
   output logic [N*DW-1:0] s_rdata,
   output logic [N-1:0]    s_ack,
   output logic [N-1:0]    s_err,
   output logic [AW-1:0]   m_addr,
   output logic [DW-1:0]   m_wdata,
   output logic [MW-1:0]   m_wmsk,
   output logic            m_we,
   output logic            m_cyc,
   input  logic [DW-1:0]   m_rdata,
   input  logic            m_ack,
   output logic [N-1:0]    grant,
   output logic            tmo_evt
);
   localparam int            BW       = AW + DW + MW + 1;
   localparam int            CW       = cnt_width(TMO);
   localparam logic [CW-1:0] TMO_LAST = CW'((TMO > 0) ? TMO - 1 : 0);
   localparam logic [N-1:0]  LAST_RST = {1'b1, {(N-1){1'b0}}};

   arb_state_t    state_q, state_d;
   logic [N-1:0]  grant_q, grant_d;
   logic [N-1:0]  last_q, last_d;
   logic [N-1:0]  pick;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [BW-1:0] bus_q, bus_d;
   logic [BW-1:0] sel_acc [N+1];
   logic          tmo_hit;

   // The owner is excluded so a requester still holding s_cyc after its ack
   // cannot be re-granted back-to-back while others wait.
   wb_rr_pick #(.N(N)) u_pick (
      .req_i  (s_cyc),
      .last_i (last_q),
      .excl_i (grant_q),
      .gnt_o  (pick)
   );

   assign sel_acc[0] = '0;
   for (genvar gi = 0; gi < N; gi++) begin : g_port
      assign sel_acc[gi+1] = sel_acc[gi] |
         (pick[gi] ? {s_addr[gi*AW +: AW], s_wdata[gi*DW +: DW], s_wmsk[gi*MW +: MW], s_we[gi]} : '0);
      assign s_rdata[gi*DW +: DW] = grant_q[gi] ? m_rdata : '0;
   end

   // An ack in the final watchdog cycle takes precedence over the abort.
   assign tmo_hit = (TMO > 0) && (state_q == ST_BUSY) && !m_ack && (cnt_q == TMO_LAST);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      bus_d   = bus_q;
      case (state_q)
         ST_IDLE: begin
            if (|pick) begin
               grant_d = pick;
               last_d  = pick;
               cnt_d   = '0;
               bus_d   = sel_acc[N];
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (m_ack) begin
               if (|pick) begin
                  grant_d = pick;
                  last_d  = pick;
                  cnt_d   = '0;
                  bus_d   = sel_acc[N];
               end else begin
                  grant_d = '0;
                  state_d = ST_IDLE;
               end
            end else if (tmo_hit) begin
               grant_d = '0;
               state_d = ST_RECOVER;
            end else if (TMO > 0) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_RECOVER: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= LAST_RST;
         cnt_q   <= '0;
         bus_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         bus_q   <= bus_d;
      end
   end

   assign m_cyc   = (state_q == ST_BUSY);
   assign grant   = grant_q;
   assign s_ack   = grant_q & {N{m_ack}};
   assign s_err   = grant_q & {N{tmo_hit}};
   assign tmo_evt = tmo_hit;
   assign {m_addr, m_wdata, m_wmsk, m_we} = bus_q;

endmodule
